neuron_tdm_scheduler: RTL
=========================

Name: neuron_tdm_scheduler

Overview:
- Time-multiplexes one 4-stage Q3.12 neuron core (inputs i, v, w; outputs v_out, w_out) across N virtual neurons.
- Holds per-neuron v/w state and input-current registers, and issues one neuron per cycle into the core on each timestep.
- Writes core results back into state, flags rising-edge threshold crossings as spikes, and reports step completion with a start/done handshake.
- Sits between the host/step controller and the core instance.

Parameters:
- N, 16, number of virtual neurons (>=1); ID_W = clog2(N), minimum 1.
- W, 16, data width, Q3.12 signed (1 sign, 3 integer, 12 fraction bits).
- CORE_LAT, 4, cycles from core input drive to matching core output.
- V_INIT, 16'hECE1, initial/clear value of every v entry.
- W_INIT, 16'hF600, initial/clear value of every w entry.
- V_TH, 16'h1000, spike threshold (+1.0), signed compare.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse: begin one timestep (honoured only in IDLE)
- clear  in  1  pulse: reload all v/w to V_INIT/W_INIT (honoured only in IDLE)
- i_we  in  1  write enable for a current register
- i_addr  in  ID_W  current register index
- i_data  in  W  signed input current
- rd_addr  in  ID_W  state read index
- rd_v  out  W  v[rd_addr], combinational
- rd_w  out  W  w[rd_addr], combinational
- core_i  out  W  current of the issued neuron
- core_v  out  W  v of the issued neuron
- core_w  out  W  w of the issued neuron
- core_v_out  in  W  core v result
- core_w_out  in  W  core w result
- busy  out  1  step in progress
- done  out  1  one-cycle pulse: step complete
- spike_valid  out  1  one-cycle pulse: spike detected
- spike_id  out  ID_W  neuron that spiked
- step_count  out  16  completed steps, wraps 0xFFFF->0

Behaviour:
- Reset (async): FSM to IDLE; all v=V_INIT, w=W_INIT, i=0.
- Reset also clears: issue pointer, tag pipeline valids, busy, done, spike_valid, spike_id, step_count.
- FSM states: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start=1 enters ISSUE with ptr=0.
  - clear=1 (start=0) reloads all entries on that edge.
  - If start and clear are both high, start wins and clear is ignored.
- ISSUE:
  - Each cycle, core_i/core_v/core_w = i[ptr]/v[ptr]/w[ptr] (combinational from ptr).
  - Push {valid=1, id=ptr} into a CORE_LAT-deep tag shift register; ptr++.
  - After id N-1 is issued, go to DRAIN.
- DRAIN: push valid=0 tags; when the tag leaving the shift register is id N-1, go to DONE.
- DONE: done=1 for one cycle, step_count++, then IDLE.
- busy=1 in ISSUE and DRAIN only.
- Timing (start sampled at the edge ending cycle 0):
  - Issue in cycles 1..N.
  - Writeback of id k in cycle k+1+CORE_LAT.
  - done in cycle N+CORE_LAT+2.
- Writeback: when the output tag is valid, v[id]<=core_v_out and w[id]<=core_w_out at the end of that cycle.
- Spike detection:
  - Condition: core_v_out >= V_TH and the stored (pre-writeback) v[id] < V_TH, both signed.
  - Response: spike_valid=1 and spike_id=id on the following cycle.
  - No v/w modification on a spike.
- Outside ISSUE, core_* drive the ptr=0 entry values; the core pipeline is free-running and its output is ignored unless tagged.
- start or clear while not in IDLE: ignored, no queuing.
- Host current write:
  - Allowed in any state; takes effect at the clock edge.
  - Same cycle as the issue of that index: the issue uses the old value.
- rd_v/rd_w return the memory content, including partially updated state mid-step.
- Reset mid-step: everything returns to reset values immediately; no done, no writeback.
- Stale core outputs after reset are discarded because the tag valids are cleared.

Test Plan:
- Reset.
  - Stimulus: assert rst; sweep rd_addr 0..15.
  - Required: rd_v=0xECE1, rd_w=0xF600, busy=0, done=0, spike_valid=0, step_count=0.
- Full step.
  - Stimulus: N=16, CORE_LAT=4; core model = 4-cycle delay returning v+0x0010, w+0x0001; i[k]=k; start at cycle 0.
  - Required: core_i=k in cycle k+1; busy cycles 1..20; done only in cycle 22; step_count=1; v[k]=0xECF1, w[k]=0xF601.
- Spike edge.
  - Stimulus: preset v[5]=0x0FFF with the model returning 0x1000 for id 5; run a second step returning 0x1000 again.
  - Required: step 1 gives one spike_valid with spike_id=5; step 2 gives no spike.
- Ignored commands.
  - Stimulus: start and clear pulsed in cycle 8 of a step; i_we to index 3 in cycle 4 (issue of id 3).
  - Required: a single done; state not cleared; id 3 uses the old current and the new value is visible next step.
- Reset mid-step.
  - Stimulus: rst in cycle 10, released in cycle 12.
  - Required: no done, no spike_valid; all entries at V_INIT/W_INIT; a subsequent start completes normally.
- Clear.
  - Stimulus: after two steps, clear in IDLE.
  - Required: all entries return to init values; step_count stays 2.

Source files
------------

// File: rtl/neuron_tdm_scheduler.sv
// Time-multiplexes one pipelined Q3.12 neuron core across N virtual neurons:
// holds per-neuron v/w/i state, tags in-flight issues, writes results back and flags spikes.
module neuron_tdm_scheduler #(
    parameter int            N        = 16,
    parameter int            W        = 16,
    parameter int            CORE_LAT = 4,
    parameter logic [W-1:0]  V_INIT   = 16'hECE1,
    parameter logic [W-1:0]  W_INIT   = 16'hF600,
    parameter logic [W-1:0]  V_TH     = 16'h1000,
    localparam int           ID_W     = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            clear,
    input  logic            i_we,
    input  logic [ID_W-1:0] i_addr,
    input  logic [W-1:0]    i_data,
    input  logic [ID_W-1:0] rd_addr,
    output logic [W-1:0]    rd_v,
    output logic [W-1:0]    rd_w,
    output logic [W-1:0]    core_i,
    output logic [W-1:0]    core_v,
    output logic [W-1:0]    core_w,
    input  logic [W-1:0]    core_v_out,
    input  logic [W-1:0]    core_w_out,
    output logic            busy,
    output logic            done,
    output logic            spike_valid,
    output logic [ID_W-1:0] spike_id,
    output logic [15:0]     step_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N - 1);

    state_t                state_q, state_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic signed [W-1:0]   v_q [N];
    logic signed [W-1:0]   v_d [N];
    logic signed [W-1:0]   w_q [N];
    logic signed [W-1:0]   w_d [N];
    logic signed [W-1:0]   i_q [N];
    logic signed [W-1:0]   i_d [N];
    logic [CORE_LAT-1:0]   tag_vld_q, tag_vld_d;
    logic [ID_W-1:0]       tag_id_q [CORE_LAT];
    logic [ID_W-1:0]       tag_id_d [CORE_LAT];
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  spike_valid_q, spike_valid_d;
    logic [ID_W-1:0]       spike_id_q, spike_id_d;
    logic [15:0]           step_count_q, step_count_d;
    logic                  clear_en;
    logic                  wb_vld;
    logic [ID_W-1:0]       wb_id;

    // Rising-edge threshold crossing: new value at/above threshold, stored value below it.
    function automatic logic crosses_up(input logic signed [W-1:0] v_new,
                                        input logic signed [W-1:0] v_old);
        return (v_new >= $signed(V_TH)) && (v_old < $signed(V_TH));
    endfunction

    assign wb_vld      = tag_vld_q[CORE_LAT-1];
    assign wb_id       = tag_id_q[CORE_LAT-1];

    assign core_i      = i_q[ptr_q];
    assign core_v      = v_q[ptr_q];
    assign core_w      = w_q[ptr_q];
    assign rd_v        = v_q[rd_addr];
    assign rd_w        = w_q[rd_addr];

    assign busy        = busy_q;
    assign done        = done_q;
    assign spike_valid = spike_valid_q;
    assign spike_id    = spike_id_q;
    assign step_count  = step_count_q;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        step_count_d = step_count_q;
        clear_en     = 1'b0;

        // Tag pipeline mirrors the core latency so each result finds its neuron id.
        for (int s = CORE_LAT - 1; s > 0; s--) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_id_d[s]  = tag_id_q[s-1];
        end
        tag_vld_d[0] = 1'b0;
        tag_id_d[0]  = ptr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    ptr_d   = '0;
                    busy_d  = 1'b1;
                end else if (clear) begin
                    clear_en = 1'b1;
                end
            end
            ISSUE: begin
                tag_vld_d[0] = 1'b1;
                busy_d       = 1'b1;
                if (ptr_q == LAST_ID) begin
                    state_d = DRAIN;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + ID_W'(1);
                end
            end
            DRAIN: begin
                if (wb_vld && wb_id == LAST_ID) begin
                    state_d = DONE;
                end else begin
                    busy_d = 1'b1;
                end
            end
            DONE: begin
                done_d       = 1'b1;
                step_count_d = step_count_q + 16'd1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        v_d = v_q;
        w_d = w_q;
        i_d = i_q;
        if (clear_en) begin
            for (int k = 0; k < N; k++) begin
                v_d[k] = V_INIT;
                w_d[k] = W_INIT;
            end
        end else if (wb_vld) begin
            v_d[wb_id] = core_v_out;
            w_d[wb_id] = core_w_out;
        end
        if (i_we && int'(i_addr) < N) begin
            i_d[i_addr] = i_data;
        end

        spike_valid_d = wb_vld && crosses_up(core_v_out, v_q[wb_id]);
        spike_id_d    = spike_valid_d ? wb_id : spike_id_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            tag_vld_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            spike_valid_q <= 1'b0;
            spike_id_q    <= '0;
            step_count_q  <= '0;
            for (int s = 0; s < CORE_LAT; s++) begin
                tag_id_q[s] <= '0;
            end
            for (int k = 0; k < N; k++) begin
                v_q[k] <= V_INIT;
                w_q[k] <= W_INIT;
                i_q[k] <= '0;
            end
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            tag_vld_q     <= tag_vld_d;
            tag_id_q      <= tag_id_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            spike_valid_q <= spike_valid_d;
            spike_id_q    <= spike_id_d;
            step_count_q  <= step_count_d;
            v_q           <= v_d;
            w_q           <= w_d;
            i_q           <= i_d;
        end
    end

endmodule
